fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter N, default 32, meaning width of the PC, address and instruction.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of queue entries; it SHALL be a power of two and at least 2.
REQ-003 SHALL have clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have in_PC_dw  input  N  meaning fetch address from the PC register.
REQ-006 SHALL have in_PCValid  input  1  meaning in_PC_dw is offered for fetch.
REQ-007 SHALL have o_PCReady  output  1  meaning the queue accepts in_PC_dw this cycle; low means the PC stage stalls.
REQ-008 SHALL have o_IMemReq  output  1  meaning instruction-memory read request.
REQ-009 SHALL have o_IMemAddr_dw  output  N  meaning instruction-memory read address.
REQ-010 SHALL have in_IMemAck  input  1  meaning memory returns in_IMemData_dw this cycle.
REQ-011 SHALL have in_IMemData_dw  input  N  meaning returned instruction word.
REQ-012 SHALL have o_Instr_dw  output  N  meaning instruction at the queue head.
REQ-013 SHALL have o_InstrPC_dw  output  N  meaning PC of the head instruction.
REQ-014 SHALL have o_InstrValid  output  1  meaning the head entry is valid.
REQ-015 SHALL have in_DecodeReady  input  1  meaning decode consumes the head this cycle.
REQ-016 SHALL have in_Flush  input  1  meaning branch/jump redirect; discard all queued and in-flight fetches.
REQ-017 SHALL have o_DropCount_dw  output  16  meaning count of discarded memory responses.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_ACK, DROP.
REQ-019 o_PCReady SHALL be 1 only when state==IDLE, count<DEPTH, and in_Flush==0.
REQ-020 On in_PCValid && o_PCReady: latch in_PC_dw into o_IMemAddr_dw, set o_IMemReq=1, go to WAIT_ACK on the next edge.
REQ-021 o_IMemReq and o_IMemAddr_dw SHALL hold steady until the cycle in_IMemAck=1; at most one request outstanding.
REQ-022 WAIT_ACK with in_IMemAck && !in_Flush: write {in_IMemData_dw, o_IMemAddr_dw} at the tail, clear o_IMemReq, go to IDLE.
REQ-023 WAIT_ACK with in_Flush && !in_IMemAck: go to DROP, keeping the request asserted.
REQ-024 WAIT_ACK with in_Flush && in_IMemAck: discard the data, clear o_IMemReq, go to IDLE.
REQ-025 DROP with in_IMemAck: discard the data, clear o_IMemReq, go to IDLE; a further in_Flush in DROP SHALL keep the state in DROP.
REQ-026 in_IMemAck in IDLE SHALL be ignored.
REQ-027 o_InstrValid SHALL equal (count!=0); o_Instr_dw and o_InstrPC_dw SHALL reflect the head entry combinationally with zero-cycle latency from the storage.
REQ-028 Pop SHALL occur when o_InstrValid && in_DecodeReady && !in_Flush.
REQ-029 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-030 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-031 in_Flush SHALL set count, head and tail to 0 on the next edge, with priority over push and pop.
REQ-032 Throughput: one instruction per two cycles minimum with a zero-wait memory (accept, then ack); the queue SHALL never overflow, since acceptance requires a free slot.

Reset
REQ-033 While reset==0, state SHALL be IDLE, count/head/tail SHALL be 0, and all storage SHALL be 0.
REQ-034 Reset values SHALL be o_IMemReq=0, o_IMemAddr_dw=0, o_InstrValid=0, o_Instr_dw=0, o_InstrPC_dw=0, o_DropCount_dw=0, and o_PCReady=1 when in_Flush=0.
REQ-035 Reset asserted mid-transaction SHALL abandon the outstanding request immediately, with no response discarded or counted.

Configuration
REQ-036 With macro FETCH_QUEUE_DROP_CNT_EN defined, o_DropCount_dw SHALL increment by 1 per response discarded under REQ-024 or REQ-025, saturating at 0xFFFF.
REQ-037 Without FETCH_QUEUE_DROP_CNT_EN, o_DropCount_dw SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-038 Sequence: reset, then PC=0x400000 valid with ack one cycle after the request and data 0x20080005 -> o_InstrValid=1 with o_Instr_dw=0x20080005 and o_InstrPC_dw=0x400000.
REQ-039 Fill: in_DecodeReady=0 with PCs 0x0, 0x4, 0x8, 0xC acked -> count=4 and o_PCReady=0; one pop restores o_PCReady=1, and the next entry stores at wrapped tail 0.
REQ-040 Flush in WAIT_ACK with ack 3 cycles later -> o_IMemReq held through the ack, o_InstrValid=0, and o_DropCount_dw=1 (macro on) or 0 (macro off).
REQ-041 Flush and ack in the same cycle with 2 entries queued -> queue empty next cycle, IDLE, data discarded.
REQ-042 Reset deasserted-asserted during WAIT_ACK -> o_IMemReq=0 immediately, and all outputs at their REQ-034 values.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one outstanding I-mem read at a time and buffers returned words in a FIFO.
// Optional macro FETCH_QUEUE_DROP_CNT_EN enables a saturating counter of responses discarded after a flush.
module fetch_queue #(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] in_PC_dw,
   input  logic         in_PCValid,
   output logic         o_PCReady,
   output logic         o_IMemReq,
   output logic [N-1:0] o_IMemAddr_dw,
   input  logic         in_IMemAck,
   input  logic [N-1:0] in_IMemData_dw,
   output logic [N-1:0] o_Instr_dw,
   output logic [N-1:0] o_InstrPC_dw,
   output logic         o_InstrValid,
   input  logic         in_DecodeReady,
   input  logic         in_Flush,
   output logic [15:0]  o_DropCount_dw
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_ACK = 2'd1;
   localparam logic [1:0] DROP     = 2'd2;

   logic [1:0]    r_state;
   logic          r_req;
   logic [N-1:0]  r_addr;
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   logic [N-1:0]  r_instr [DEPTH];
   logic [N-1:0]  r_pc    [DEPTH];

   logic w_accept;
   logic w_push;
   logic w_pop;
   logic w_valid;

   assign w_valid   = (r_count != '0);
   assign o_PCReady = (r_state == IDLE) && (r_count < FULL) && !in_Flush;
   assign w_accept  = in_PCValid && o_PCReady;
   // A flush during WAIT_ACK turns the pending response into a drop, so no push then.
   assign w_push    = (r_state == WAIT_ACK) && in_IMemAck && !in_Flush;
   assign w_pop     = w_valid && in_DecodeReady && !in_Flush;

   assign o_IMemReq     = r_req;
   assign o_IMemAddr_dw = r_addr;
   assign o_InstrValid  = w_valid;
   assign o_Instr_dw    = r_instr[r_head];
   assign o_InstrPC_dw  = r_pc[r_head];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_addr  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr  <= in_PC_dw;
                  r_req   <= 1'b1;
                  r_state <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (in_IMemAck) begin
                  r_req   <= 1'b0;
                  r_state <= IDLE;
               end else if (in_Flush) begin
                  r_state <= DROP;
               end
            end
            DROP: begin
               if (in_IMemAck) begin
                  r_req   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (in_Flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_instr[gi] <= '0;
               r_pc[gi]    <= '0;
            end else if (w_push && (r_tail == AW'(gi))) begin
               r_instr[gi] <= in_IMemData_dw;
               r_pc[gi]    <= r_addr;
            end
         end
      end
   endgenerate

`ifdef FETCH_QUEUE_DROP_CNT_EN
   logic        w_drop;
   logic [15:0] r_drop_cnt;

   assign w_drop = in_IMemAck &&
                   (((r_state == WAIT_ACK) && in_Flush) || (r_state == DROP));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_drop_cnt <= '0;
      end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign o_DropCount_dw = r_drop_cnt;
`else
   assign o_DropCount_dw = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, single fetch, fill/wrap, push+pop, flush cases, mid-transaction reset.
// Expected drop counts follow FETCH_QUEUE_DROP_CNT_EN.
module tb_fetch_queue;
   localparam int N = 32;
`ifdef FETCH_QUEUE_DROP_CNT_EN
   localparam int DROP_ON = 1;
`else
   localparam int DROP_ON = 0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] in_PC_dw = '0;
   logic         in_PCValid = 1'b0;
   logic         o_PCReady;
   logic         o_IMemReq;
   logic [N-1:0] o_IMemAddr_dw;
   logic         in_IMemAck = 1'b0;
   logic [N-1:0] in_IMemData_dw = '0;
   logic [N-1:0] o_Instr_dw;
   logic [N-1:0] o_InstrPC_dw;
   logic         o_InstrValid;
   logic         in_DecodeReady = 1'b0;
   logic         in_Flush = 1'b0;
   logic [15:0]  o_DropCount_dw;

   int total = 0;
   int bad = 0;

   fetch_queue #(.N(N), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .in_PC_dw(in_PC_dw), .in_PCValid(in_PCValid), .o_PCReady(o_PCReady),
      .o_IMemReq(o_IMemReq), .o_IMemAddr_dw(o_IMemAddr_dw),
      .in_IMemAck(in_IMemAck), .in_IMemData_dw(in_IMemData_dw),
      .o_Instr_dw(o_Instr_dw), .o_InstrPC_dw(o_InstrPC_dw), .o_InstrValid(o_InstrValid),
      .in_DecodeReady(in_DecodeReady), .in_Flush(in_Flush), .o_DropCount_dw(o_DropCount_dw)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Offer a PC, then ack it one cycle later with the given data.
   task automatic push_entry(input logic [N-1:0] pc, input logic [N-1:0] data);
      in_PC_dw = pc;
      in_PCValid = 1'b1;
      cyc();
      in_PCValid = 1'b0;
      in_IMemAck = 1'b1;
      in_IMemData_dw = data;
      cyc();
      in_IMemAck = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cyc(); cyc();
      #1;
      total++; if (o_IMemReq !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", o_IMemReq); end
      total++; if (o_IMemAddr_dw !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", o_IMemAddr_dw); end
      total++; if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", o_InstrValid); end
      total++; if (o_Instr_dw !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", o_Instr_dw); end
      total++; if (o_InstrPC_dw !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", o_InstrPC_dw); end
      total++; if (o_DropCount_dw !== 16'h0) begin bad++; $display("FAIL rst_drop: got %h want 0", o_DropCount_dw); end
      total++; if (o_PCReady !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", o_PCReady); end
      reset = 1'b1;
      cyc();
      $display("test_reset done");
   endtask

   task automatic test_single_fetch();
      in_PC_dw = 32'h0040_0000;
      in_PCValid = 1'b1;
      #1;
      total++; if (o_PCReady !== 1'b1) begin bad++; $display("FAIL sf_ready: got %b want 1", o_PCReady); end
      cyc();
      in_PCValid = 1'b0;
      #1;
      total++; if (o_IMemReq !== 1'b1) begin bad++; $display("FAIL sf_req: got %b want 1", o_IMemReq); end
      total++; if (o_IMemAddr_dw !== 32'h0040_0000) begin bad++; $display("FAIL sf_addr: got %h want 00400000", o_IMemAddr_dw); end
      total++; if (o_PCReady !== 1'b0) begin bad++; $display("FAIL sf_busy: got %b want 0", o_PCReady); end
      cyc();
      #1;
      total++; if (o_IMemReq !== 1'b1) begin bad++; $display("FAIL sf_hold: got %b want 1", o_IMemReq); end
      in_IMemAck = 1'b1;
      in_IMemData_dw = 32'h2008_0005;
      cyc();
      in_IMemAck = 1'b0;
      #1;
      total++; if (o_InstrValid !== 1'b1) begin bad++; $display("FAIL sf_valid: got %b want 1", o_InstrValid); end
      total++; if (o_Instr_dw !== 32'h2008_0005) begin bad++; $display("FAIL sf_instr: got %h want 20080005", o_Instr_dw); end
      total++; if (o_InstrPC_dw !== 32'h0040_0000) begin bad++; $display("FAIL sf_pc: got %h want 00400000", o_InstrPC_dw); end
      total++; if (o_IMemReq !== 1'b0) begin bad++; $display("FAIL sf_reqclr: got %b want 0", o_IMemReq); end
      // stray ack in IDLE must not enqueue anything
      in_IMemAck = 1'b1;
      in_IMemData_dw = 32'hDEAD_BEEF;
      cyc();
      in_IMemAck = 1'b0;
      #1;
      total++; if (o_Instr_dw !== 32'h2008_0005) begin bad++; $display("FAIL sf_idleack: got %h want 20080005", o_Instr_dw); end
      in_DecodeReady = 1'b1;
      cyc();
      in_DecodeReady = 1'b0;
      #1;
      total++; if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL sf_pop: got %b want 0", o_InstrValid); end
      $display("test_single_fetch done");
   endtask

   task automatic test_fill_wrap();
      logic [N-1:0] exp_pc [4];
      logic [N-1:0] exp_in [4];
      in_Flush = 1'b1;
      #1;
      total++; if (o_PCReady !== 1'b0) begin bad++; $display("FAIL fw_flushready: got %b want 0", o_PCReady); end
      cyc();
      in_Flush = 1'b0;
      push_entry(32'h0, 32'hA0);
      push_entry(32'h4, 32'hA1);
      push_entry(32'h8, 32'hA2);
      push_entry(32'hC, 32'hA3);
      #1;
      total++; if (o_PCReady !== 1'b0) begin bad++; $display("FAIL fw_full: got %b want 0", o_PCReady); end
      total++; if (o_InstrPC_dw !== 32'h0) begin bad++; $display("FAIL fw_head: got %h want 0", o_InstrPC_dw); end
      total++; if (o_Instr_dw !== 32'hA0) begin bad++; $display("FAIL fw_headi: got %h want a0", o_Instr_dw); end
      in_PC_dw = 32'h99;
      in_PCValid = 1'b1;
      cyc();
      in_PCValid = 1'b0;
      #1;
      total++; if (o_IMemReq !== 1'b0) begin bad++; $display("FAIL fw_noaccept: got %b want 0", o_IMemReq); end
      in_DecodeReady = 1'b1;
      cyc();
      in_DecodeReady = 1'b0;
      #1;
      total++; if (o_PCReady !== 1'b1) begin bad++; $display("FAIL fw_ready: got %b want 1", o_PCReady); end
      total++; if (o_InstrPC_dw !== 32'h4) begin bad++; $display("FAIL fw_head2: got %h want 4", o_InstrPC_dw); end
      push_entry(32'h10, 32'hA4);
      exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
      exp_in = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (o_InstrPC_dw !== exp_pc[i]) begin bad++; $display("FAIL fw_drain_pc%0d: got %h want %h", i, o_InstrPC_dw, exp_pc[i]); end
         total++; if (o_Instr_dw !== exp_in[i]) begin bad++; $display("FAIL fw_drain_in%0d: got %h want %h", i, o_Instr_dw, exp_in[i]); end
         in_DecodeReady = 1'b1;
         cyc();
         in_DecodeReady = 1'b0;
      end
      #1;
      total++; if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL fw_empty: got %b want 0", o_InstrValid); end
      $display("test_fill_wrap done");
   endtask

   task automatic test_back_to_back();
      push_entry(32'h500, 32'hB0);
      in_PC_dw = 32'h504;
      in_PCValid = 1'b1;
      cyc();
      in_PCValid = 1'b0;
      in_IMemAck = 1'b1;
      in_IMemData_dw = 32'hB1;
      in_DecodeReady = 1'b1;
      cyc();
      in_IMemAck = 1'b0;
      in_DecodeReady = 1'b0;
      #1;
      total++; if (o_InstrValid !== 1'b1) begin bad++; $display("FAIL bb_valid: got %b want 1", o_InstrValid); end
      total++; if (o_InstrPC_dw !== 32'h504) begin bad++; $display("FAIL bb_pc: got %h want 504", o_InstrPC_dw); end
      total++; if (o_Instr_dw !== 32'hB1) begin bad++; $display("FAIL bb_instr: got %h want b1", o_Instr_dw); end
      in_DecodeReady = 1'b1;
      cyc();
      in_DecodeReady = 1'b0;
      #1;
      total++; if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL bb_empty: got %b want 0", o_InstrValid); end
      $display("test_back_to_back done");
   endtask

   task automatic test_flush_wait();
      push_entry(32'h600, 32'hC0);
      in_PC_dw = 32'h100;
      in_PCValid = 1'b1;
      cyc();
      in_PCValid = 1'b0;
      in_Flush = 1'b1;
      cyc();
      cyc();
      in_Flush = 1'b0;
      #1;
      total++; if (o_IMemReq !== 1'b1) begin bad++; $display("FAIL fl_req: got %b want 1", o_IMemReq); end
      total++; if (o_IMemAddr_dw !== 32'h100) begin bad++; $display("FAIL fl_addr: got %h want 100", o_IMemAddr_dw); end
      total++; if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL fl_valid: got %b want 0", o_InstrValid); end
      total++; if (o_PCReady !== 1'b0) begin bad++; $display("FAIL fl_dropready: got %b want 0", o_PCReady); end
      cyc();
      #1;
      total++; if (o_IMemReq !== 1'b1) begin bad++; $display("FAIL fl_req2: got %b want 1", o_IMemReq); end
      in_IMemAck = 1'b1;
      in_IMemData_dw = 32'hBAD0;
      cyc();
      in_IMemAck = 1'b0;
      #1;
      total++; if (o_IMemReq !== 1'b0) begin bad++; $display("FAIL fl_reqclr: got %b want 0", o_IMemReq); end
      total++; if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL fl_valid2: got %b want 0", o_InstrValid); end
      total++; if (o_DropCount_dw !== 16'(DROP_ON)) begin bad++; $display("FAIL fl_drop: got %0d want %0d", o_DropCount_dw, DROP_ON); end
      total++; if (o_PCReady !== 1'b1) begin bad++; $display("FAIL fl_ready: got %b want 1", o_PCReady); end
      $display("test_flush_wait done");
   endtask

   task automatic test_flush_ack_same();
      push_entry(32'h200, 32'hD0);
      push_entry(32'h204, 32'hD1);
      in_PC_dw = 32'h208;
      in_PCValid = 1'b1;
      cyc();
      in_PCValid = 1'b0;
      in_IMemAck = 1'b1;
      in_Flush = 1'b1;
      in_IMemData_dw = 32'hBAD2;
      cyc();
      in_IMemAck = 1'b0;
      in_Flush = 1'b0;
      #1;
      total++; if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL fa_valid: got %b want 0", o_InstrValid); end
      total++; if (o_IMemReq !== 1'b0) begin bad++; $display("FAIL fa_req: got %b want 0", o_IMemReq); end
      total++; if (o_PCReady !== 1'b1) begin bad++; $display("FAIL fa_ready: got %b want 1", o_PCReady); end
      total++; if (o_DropCount_dw !== 16'(2*DROP_ON)) begin bad++; $display("FAIL fa_drop: got %0d want %0d", o_DropCount_dw, 2*DROP_ON); end
      push_entry(32'h20C, 32'hD3);
      #1;
      total++; if (o_InstrPC_dw !== 32'h20C) begin bad++; $display("FAIL fa_newpc: got %h want 20c", o_InstrPC_dw); end
      total++; if (o_Instr_dw !== 32'hD3) begin bad++; $display("FAIL fa_newin: got %h want d3", o_Instr_dw); end
      $display("test_flush_ack_same done");
   endtask

   task automatic test_reset_mid();
      in_PC_dw = 32'h300;
      in_PCValid = 1'b1;
      cyc();
      in_PCValid = 1'b0;
      #1;
      total++; if (o_IMemReq !== 1'b1) begin bad++; $display("FAIL rm_req: got %b want 1", o_IMemReq); end
      reset = 1'b0;
      #1;
      total++; if (o_IMemReq !== 1'b0) begin bad++; $display("FAIL rm_reqclr: got %b want 0", o_IMemReq); end
      total++; if (o_IMemAddr_dw !== 32'h0) begin bad++; $display("FAIL rm_addr: got %h want 0", o_IMemAddr_dw); end
      total++; if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", o_InstrValid); end
      total++; if (o_Instr_dw !== 32'h0) begin bad++; $display("FAIL rm_instr: got %h want 0", o_Instr_dw); end
      total++; if (o_InstrPC_dw !== 32'h0) begin bad++; $display("FAIL rm_pc: got %h want 0", o_InstrPC_dw); end
      total++; if (o_DropCount_dw !== 16'h0) begin bad++; $display("FAIL rm_drop: got %h want 0", o_DropCount_dw); end
      total++; if (o_PCReady !== 1'b1) begin bad++; $display("FAIL rm_ready: got %b want 1", o_PCReady); end
      in_IMemAck = 1'b1;
      in_IMemData_dw = 32'hBAD3;
      cyc();
      in_IMemAck = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      #1;
      total++; if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL rm_valid2: got %b want 0", o_InstrValid); end
      total++; if (o_DropCount_dw !== 16'h0) begin bad++; $display("FAIL rm_drop2: got %h want 0", o_DropCount_dw); end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_fill_wrap();
      test_back_to_back();
      test_flush_wait();
      test_flush_ack_same();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
